// File: rtl/axi_lite_cam_regs.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_cam_regs
//  Brief    : AXI4-Lite responder holding the camera CTRL/CONFIG registers,
//             a live STATUS word and a sticky write-one-to-clear IRQ register.
//             Addresses 0x10-0x1C are unmapped and answer SLVERR.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_cam_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] CTRL_RESET         = 32'h0000_0000
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  // write response channel
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  // camera side
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_o,
  output logic                            start_pulse_o,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   status_i,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   irq_event_i,
  output logic                            irq_o
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = C_S_AXI_DATA_WIDTH / 8;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  localparam logic [IDX_W-1:0] REG_CTRL   = IDX_W'(0);
  localparam logic [IDX_W-1:0] REG_CFG    = IDX_W'(1);
  localparam logic [IDX_W-1:0] REG_STATUS = IDX_W'(2);
  localparam logic [IDX_W-1:0] REG_IRQ    = IDX_W'(3);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // ready enable: keeps all READYs low until the first cycle after reset release
  logic             rdy_en_q,   rdy_en_d;
  // write holding registers
  logic             aw_held_q,  aw_held_d;
  logic [IDX_W-1:0] aw_idx_q,   aw_idx_d;
  logic             w_held_q,   w_held_d;
  logic [DW-1:0]    w_data_q,   w_data_d;
  logic [SW-1:0]    w_strb_q,   w_strb_d;
  // write response
  logic             bvalid_q,   bvalid_d;
  logic [1:0]       bresp_q,    bresp_d;
  // read response
  logic             rvalid_q,   rvalid_d;
  logic [1:0]       rresp_q,    rresp_d;
  logic [DW-1:0]    rdata_q,    rdata_d;
  // register file
  logic [DW-1:0]    ctrl_q,     ctrl_d;
  logic [DW-1:0]    cfg_q,      cfg_d;
  logic [DW-1:0]    irq_q,      irq_d;
  logic             start_pulse_q, start_pulse_d;

  // combinational helpers
  logic             awready, wready, arready;
  logic             aw_hs, w_hs, ar_hs;
  logic             wr_go;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [DW-1:0]    wr_data;
  logic [SW-1:0]    wr_strb;
  logic [DW-1:0]    wr_mask;
  logic [DW-1:0]    ctrl_base;
  logic [DW-1:0]    w1c_mask;
  logic             unused_addr_lsb;

  // the byte offset inside a word carries no meaning
  assign unused_addr_lsb = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign awready = rdy_en_q && !aw_held_q && !bvalid_q;
  assign wready  = rdy_en_q && !w_held_q  && !bvalid_q;
  assign arready = rdy_en_q && !rvalid_q;

  assign aw_hs = S_AXI_AWVALID && awready;
  assign w_hs  = S_AXI_WVALID  && wready;
  assign ar_hs = S_AXI_ARVALID && arready;

  // A write commits as soon as both halves are available, whether they are
  // already held or are handshaking in this very cycle.
  assign wr_go   = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_data = w_held_q  ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_held_q  ? w_strb_q : S_AXI_WSTRB;
  assign rd_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // CTRL bit0 is a one-shot: it never survives more than one cycle
  assign ctrl_base = {ctrl_q[DW-1:1], 1'b0};

  // expand byte strobes into a bit mask
  generate
    for (genvar i = 0; i < SW; i++) begin : g_lane
      assign wr_mask[8*i +: 8] = {8{wr_strb[i]}};
    end
  endgenerate

  // write path: capture AW/W, commit to the register file, produce B response
  always_comb begin
    aw_held_d     = aw_held_q;
    aw_idx_d      = aw_idx_q;
    w_held_d      = w_held_q;
    w_data_d      = w_data_q;
    w_strb_d      = w_strb_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    ctrl_d        = ctrl_base;
    cfg_d         = cfg_q;
    start_pulse_d = 1'b0;
    w1c_mask      = '0;

    if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end

    if (wr_go) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OKAY;
      case (wr_idx)
        REG_CTRL: begin
          ctrl_d        = (ctrl_base & ~wr_mask) | (wr_data & wr_mask);
          start_pulse_d = wr_strb[0] & wr_data[0];
        end
        REG_CFG: begin
          cfg_d = (cfg_q & ~wr_mask) | (wr_data & wr_mask);
        end
        REG_STATUS: begin
          // read-only word: write accepted and discarded
        end
        REG_IRQ: begin
          w1c_mask = wr_data & wr_mask;
        end
        default: begin
          bresp_d = RESP_SLVERR;
        end
      endcase
    end

    // a new event wins over a clear of the same bit
    irq_d = (irq_q & ~w1c_mask) | irq_event_i;
  end

  // read path: register RDATA/RRESP at AR handshake and hold until RREADY
  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    rdy_en_d = 1'b1;

    if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      case (rd_idx)
        REG_CTRL:   rdata_d = ctrl_q;
        REG_CFG:    rdata_d = cfg_q;
        REG_STATUS: rdata_d = status_i;
        REG_IRQ:    rdata_d = irq_q;
        default: begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end
      endcase
    end
  end

  // state registers; reset aborts any transfer in flight
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rdy_en_q      <= 1'b0;
      aw_held_q     <= 1'b0;
      aw_idx_q      <= '0;
      w_held_q      <= 1'b0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      bvalid_q      <= 1'b0;
      bresp_q       <= RESP_OKAY;
      rvalid_q      <= 1'b0;
      rresp_q       <= RESP_OKAY;
      rdata_q       <= '0;
      ctrl_q        <= CTRL_RESET[DW-1:0];
      cfg_q         <= '0;
      irq_q         <= '0;
      start_pulse_q <= 1'b0;
    end else begin
      rdy_en_q      <= rdy_en_d;
      aw_held_q     <= aw_held_d;
      aw_idx_q      <= aw_idx_d;
      w_held_q      <= w_held_d;
      w_data_q      <= w_data_d;
      w_strb_q      <= w_strb_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      rvalid_q      <= rvalid_d;
      rresp_q       <= rresp_d;
      rdata_q       <= rdata_d;
      ctrl_q        <= ctrl_d;
      cfg_q         <= cfg_d;
      irq_q         <= irq_d;
      start_pulse_q <= start_pulse_d;
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign ctrl_o        = ctrl_q;
  assign cfg_o         = cfg_q;
  assign start_pulse_o = start_pulse_q;
  assign irq_o         = |irq_q;

endmodule
`default_nettype wire
